// File: rtl/mem_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | mem_ctrl_pkg : shared types and helpers for mem_port_ctrl (rev 1.0) |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Byte 0 is the lowest address and occupies the most significant lane.
  typedef logic [0:3][7:0] byte_word_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  localparam int unsigned IDX_I = 0;
  localparam int unsigned IDX_D = 1;

  function automatic byte_word_t merge_bytes(
    input byte_word_t old_w,
    input byte_word_t new_w,
    input logic [3:0] strb
  );
    byte_word_t r;
    r = old_w;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) r[k] = new_w[k];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_ctrl_if.sv
// +--------------------------------------------------------------------+
// | mem_port_ctrl_if : fetch, load/store and memory buses (rev 1.0)     |
// +--------------------------------------------------------------------+
`default_nettype none

interface mem_port_ctrl_if;
  import mem_ctrl_pkg::*;

  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic        i_rsp_ready;
  byte_word_t  i_rsp_rdata;
  logic        i_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [3:0]  d_req_strb;
  byte_word_t  d_req_wdata;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  byte_word_t  d_rsp_rdata;
  logic        d_rsp_err;

  logic [31:0] mem_addr;
  byte_word_t  mem_data_in;
  logic        mem_we;
  byte_word_t  mem_data_out;

  // Controller side.
  modport slave (
    input  i_req_valid, i_req_addr, i_rsp_ready,
    output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    input  d_req_valid, d_req_addr, d_req_we, d_req_strb, d_req_wdata, d_rsp_ready,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output mem_addr, mem_data_in, mem_we,
    input  mem_data_out
  );

  // Core pipeline plus memory instance side.
  modport master (
    output i_req_valid, i_req_addr, i_rsp_ready,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    output d_req_valid, d_req_addr, d_req_we, d_req_strb, d_req_wdata, d_rsp_ready,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  mem_addr, mem_data_in, mem_we,
    output mem_data_out
  );

endinterface

`default_nettype wire

// File: rtl/mem_rr_arb.sv
// +--------------------------------------------------------------------+
// | mem_rr_arb : 2-way round-robin arbiter, bit0 = I, bit1 = D (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module mem_rr_arb
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  port_t last_grant_q;

  always_comb begin
    grant_o = 2'b00;
    if (req_i[IDX_D] && (!req_i[IDX_I] || (last_grant_q == PORT_I))) begin
      grant_o[IDX_D] = 1'b1;
    end else if (req_i[IDX_I]) begin
      grant_o[IDX_I] = 1'b1;
    end
  end

  // Reset to I so the first contended request after reset goes to D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_I;
    end else if (advance_i && (grant_o != 2'b00)) begin
      last_grant_q <= grant_o[IDX_D] ? PORT_D : PORT_I;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_ctrl.sv
// +--------------------------------------------------------------------+
// | mem_port_ctrl : I/D port sequencer with RMW partial stores (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TOP   = 65535,
  parameter int unsigned START = 0
) (
  input logic            clk,
  input logic            rst,
  mem_port_ctrl_if.slave bus
);

  localparam logic [31:0] C_TOP_WORD = 32'(TOP) - 32'd3;
  localparam logic [31:0] C_START    = 32'(START);

  state_t      state_q;
  port_t       port_q;
  logic [31:0] ea_q;
  logic        we_q;
  logic [3:0]  strb_q;
  byte_word_t  wdata_q;
  byte_word_t  rdata_q;
  logic        err_q;
  logic        i_rsp_valid_q;
  logic        d_rsp_valid_q;

  logic [1:0]  req;
  logic [1:0]  grant;
  logic        handshake;
  logic        sel_d;
  logic [31:0] req_addr;
  logic        below_start;
  logic        range_err;
  logic        rsp_taken;

  assign req       = {bus.d_req_valid, bus.i_req_valid};
  assign handshake = (state_q == IDLE) && (grant != 2'b00);
  assign sel_d     = grant[IDX_D];
  assign req_addr  = sel_d ? bus.d_req_addr : bus.i_req_addr;

  mem_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .advance_i (handshake),
    .grant_o   (grant)
  );

  if (START == 0) begin : g_no_low_bound
    assign below_start = 1'b0;
  end else begin : g_low_bound
    assign below_start = ((req_addr & WORD_MASK) < C_START);
  end

  // The upper bound uses the raw address so a word straddling TOP is rejected.
  assign range_err = below_start || (req_addr > C_TOP_WORD);

  assign bus.i_req_ready = (state_q == IDLE) && grant[IDX_I];
  assign bus.d_req_ready = (state_q == IDLE) && grant[IDX_D];

  assign rsp_taken = (i_rsp_valid_q && bus.i_rsp_ready) ||
                     (d_rsp_valid_q && bus.d_rsp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      port_q        <= PORT_I;
      ea_q          <= '0;
      we_q          <= 1'b0;
      strb_q        <= 4'h0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            port_q  <= sel_d ? PORT_D : PORT_I;
            ea_q    <= req_addr & WORD_MASK;
            we_q    <= sel_d && bus.d_req_we;
            strb_q  <= sel_d ? bus.d_req_strb : 4'h0;
            wdata_q <= sel_d ? bus.d_req_wdata : '0;
            err_q   <= range_err;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (err_q) begin
            rdata_q <= '0;
          end else if (!we_q || (strb_q == 4'h0)) begin
            rdata_q <= bus.mem_data_out;
          end else if (strb_q == 4'hF) begin
            rdata_q <= wdata_q;
          end else begin
            rdata_q <= merge_bytes(bus.mem_data_out, wdata_q, strb_q);
          end

          if (!err_q && we_q && (strb_q != 4'h0) && (strb_q != 4'hF)) begin
            state_q <= MERGE_WR;
          end else begin
            state_q       <= RESP;
            i_rsp_valid_q <= (port_q == PORT_I);
            d_rsp_valid_q <= (port_q == PORT_D);
          end
        end
        MERGE_WR: begin
          state_q       <= RESP;
          i_rsp_valid_q <= (port_q == PORT_I);
          d_rsp_valid_q <= (port_q == PORT_D);
        end
        RESP: begin
          if (rsp_taken) begin
            state_q       <= IDLE;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from the state register so a reset drops them at once.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_we      = 1'b0;
    bus.mem_data_in = '0;
    case (state_q)
      ACCESS: begin
        bus.mem_addr = ea_q;
        if (we_q && !err_q && (strb_q == 4'hF)) begin
          bus.mem_we      = 1'b1;
          bus.mem_data_in = wdata_q;
        end
      end
      MERGE_WR: begin
        bus.mem_addr    = ea_q;
        bus.mem_we      = 1'b1;
        bus.mem_data_in = rdata_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.i_rsp_valid = i_rsp_valid_q;
  assign bus.i_rsp_err   = i_rsp_valid_q && err_q;
  assign bus.i_rsp_rdata = i_rsp_valid_q ? rdata_q : '0;
  assign bus.d_rsp_valid = d_rsp_valid_q;
  assign bus.d_rsp_err   = d_rsp_valid_q && err_q;
  assign bus.d_rsp_rdata = d_rsp_valid_q ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_mem_port_ctrl : vector table, corner sequences, random vs model  |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned TOP   = 65535;
  localparam int unsigned START = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_ctrl_if bus ();

  mem_port_ctrl #(.TOP(TOP), .START(START)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory instance: combinational read, synchronous 4-byte write, plus a preload path.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        pl_we   = 1'b0;
  logic [15:0] pl_addr = '0;
  byte_word_t  pl_data = '0;

  function automatic logic [15:0] idx(input logic [15:0] a, input int k);
    return a + 16'(k);
  endfunction

  assign bus.mem_data_out = {mem[idx(bus.mem_addr[15:0], 0)], mem[idx(bus.mem_addr[15:0], 1)],
                             mem[idx(bus.mem_addr[15:0], 2)], mem[idx(bus.mem_addr[15:0], 3)]};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int k = 0; k < 4; k++) mem[idx(bus.mem_addr[15:0], k)] <= bus.mem_data_in[k];
    end else if (pl_we) begin
      for (int k = 0; k < 4; k++) mem[idx(pl_addr, k)] <= pl_data[k];
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke_word(input logic [15:0] a, input byte_word_t w);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = w;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  function automatic byte_word_t peek_word(input logic [15:0] a);
    byte_word_t w;
    for (int k = 0; k < 4; k++) w[k] = mem[idx(a, k)];
    return w;
  endfunction

  // Reference behaviour from the rules: range check, read, byte-merge store.
  function automatic void model(input logic [31:0] addr, input bit we, input logic [3:0] strb,
                                input byte_word_t wdata, output byte_word_t rdata,
                                output bit err, output int lat, output int wecnt);
    logic [31:0] ea;
    byte_word_t  old_w;
    ea  = {addr[31:2], 2'b00};
    err = (ea < 32'(START)) || (addr > 32'(TOP) - 32'd3);
    lat = 2;
    wecnt = 0;
    rdata = '0;
    if (err) return;
    for (int k = 0; k < 4; k++) old_w[k] = ref_mem[idx(ea[15:0], k)];
    rdata = old_w;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) rdata[k] = wdata[k];
        ref_mem[idx(ea[15:0], k)] = rdata[k];
      end
      wecnt = (strb != 4'h0) ? 1 : 0;
      lat   = (strb == 4'h0 || strb == 4'hF) ? 2 : 3;
    end
  endfunction

  // One complete transaction on one port; response taken as soon as it appears.
  task automatic do_txn(input bit is_d, input logic [31:0] addr, input bit we,
                        input logic [3:0] strb, input byte_word_t wdata,
                        output byte_word_t rdata, output bit err, output int lat,
                        output int wecnt, output logic [31:0] acc_addr);
    int t;
    @(negedge clk);
    if (is_d) begin
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = addr;
      bus.d_req_we    = we;
      bus.d_req_strb  = strb;
      bus.d_req_wdata = wdata;
    end else begin
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = addr;
    end
    #1;
    t = 0;
    while (!(is_d ? bus.d_req_ready : bus.i_req_ready) && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    chk("req_ready_timeout", 32'(t >= 20), 32'd0);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    acc_addr = bus.mem_addr;
    wecnt = 0;
    lat = 1;
    while (!(is_d ? bus.d_rsp_valid : bus.i_rsp_valid) && lat < 20) begin
      if (bus.mem_we) wecnt++;
      if (bus.mem_we && bus.mem_addr !== acc_addr) wecnt += 100;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.mem_we) wecnt++;
    rdata = is_d ? bus.d_rsp_rdata : bus.i_rsp_rdata;
    err   = is_d ? bus.d_rsp_err   : bus.i_rsp_err;
    if (is_d) bus.d_rsp_ready = 1'b1; else bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.d_rsp_ready = 1'b0;
    bus.i_rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vt[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_word_t  rd, exp_rd, wd;
    bit          er, exp_er, is_d, we;
    int          lat, wc, exp_lat, exp_wc;
    logic [31:0] acc, addr;
    logic [3:0]  strb;
    int          order[4];
    int          exp_order[4];
    int          n, t;

    bus.i_req_valid = 0; bus.i_req_addr = '0; bus.i_rsp_ready = 0;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_we = 0;
    bus.d_req_strb  = '0; bus.d_req_wdata = '0; bus.d_rsp_ready = 0;

    vt[0]  = '{0, 32'h0000_0102, 0, 4'h0, 32'h0,         32'h1122_3344, 0, 2, 0};
    vt[1]  = '{1, 32'h0000_0200, 1, 4'h2, 32'h00AB_0000, 32'h01AB_0304, 0, 3, 1};
    vt[2]  = '{1, 32'h0000_0201, 0, 4'h0, 32'h0,         32'h01AB_0304, 0, 2, 0};
    vt[3]  = '{1, 32'h0000_0010, 1, 4'hF, 32'hC0C1_C2C3, 32'hC0C1_C2C3, 0, 2, 1};
    vt[4]  = '{1, 32'h0000_0012, 0, 4'h0, 32'h0,         32'hC0C1_C2C3, 0, 2, 0};
    vt[5]  = '{1, 32'h0000_0010, 1, 4'h0, 32'hFFFF_FFFF, 32'hC0C1_C2C3, 0, 2, 0};
    vt[6]  = '{0, 32'h0000_0013, 0, 4'h0, 32'h0,         32'hC0C1_C2C3, 0, 2, 0};
    vt[7]  = '{1, 32'd65533,     0, 4'h0, 32'h0,         32'h0,         1, 2, 0};
    vt[8]  = '{1, 32'h0000_0200, 1, 4'h9, 32'hEE00_00DD, 32'hEEAB_03DD, 0, 3, 1};
    vt[9]  = '{0, 32'h0000_0203, 0, 4'h0, 32'h0,         32'hEEAB_03DD, 0, 2, 0};
    vt[10] = '{1, 32'd65532,     1, 4'hF, 32'h1234_5678, 32'h1234_5678, 0, 2, 1};
    vt[11] = '{0, 32'd65532,     0, 4'h0, 32'h0,         32'h1234_5678, 0, 2, 0};
    vt[12] = '{0, 32'd65535,     0, 4'h0, 32'h0,         32'h0,         1, 2, 0};
    vt[13] = '{1, 32'h0001_0000, 1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1, 2, 0};
    vt[14] = '{1, 32'h0000_0200, 1, 4'h6, 32'h005A_A500, 32'hEE5A_A5DD, 0, 3, 1};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_rsp_valid", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'd0);
    chk("reset_req_ready", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contended requests straight after reset: D, I, D, I
    @(negedge clk);
    bus.i_req_addr = 32'h100; bus.d_req_addr = 32'h104; bus.d_req_we = 1'b0;
    bus.i_rsp_ready = 1'b1; bus.d_rsp_ready = 1'b1;
    bus.i_req_valid = 1'b1; bus.d_req_valid = 1'b1;
    #1;
    chk("arb_first_d_ready", 32'(bus.d_req_ready), 32'd1);
    chk("arb_first_i_ready", 32'(bus.i_req_ready), 32'd0);
    order = '{default: -1};
    exp_order = '{1, 0, 1, 0};
    n = 0; t = 0;
    while (n < 4 && t < 40) begin
      if (bus.d_req_ready) begin order[n] = 1; n++; end
      else if (bus.i_req_ready) begin order[n] = 0; n++; end
      @(negedge clk); #1;
      t++;
    end
    bus.i_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_rsp_ready = 1'b0; bus.d_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("arb_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Memory preload
    poke_word(16'h0100, 32'h1122_3344);
    poke_word(16'h0200, 32'h0102_0304);
    poke_word(16'h0010, 32'hA0A1_A2A3);
    poke_word(16'hFFFC, 32'h0);
    poke_word(16'h0300, 32'h0506_0708);
    for (int a = 16'h0400; a < 16'h0440; a += 4) begin
      wd = $urandom;
      poke_word(16'(a), wd);
      for (int k = 0; k < 4; k++) ref_mem[idx(16'(a), k)] = wd[k];
    end

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      do_txn(vt[i].is_d, vt[i].addr, vt[i].we, vt[i].strb, vt[i].wdata, rd, er, lat, wc, acc);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_we_cycles", i), 32'(wc), 32'(vt[i].exp_we));
      chk($sformatf("vec%0d_mem_addr", i), acc, {vt[i].addr[31:2], 2'b00});
    end
    chk("mem_0x200_final", peek_word(16'h0200), 32'hEE5A_A5DD);
    chk("mem_0x010_final", peek_word(16'h0010), 32'hC0C1_C2C3);
    chk("mem_0x000_untouched", peek_word(16'h0000), 32'h0);

    // Error response with a stalled consumer; I must not be accepted meanwhile
    @(negedge clk);
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'd65533; bus.d_req_we = 1'b0;
    #1;
    chk("stall_d_ready", 32'(bus.d_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h100;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), 32'(bus.d_rsp_valid), 32'd1);
      chk($sformatf("stall%0d_err", c), 32'(bus.d_rsp_err), 32'd1);
      chk($sformatf("stall%0d_rdata", c), bus.d_rsp_rdata, 32'd0);
      chk($sformatf("stall%0d_i_ready", c), 32'(bus.i_req_ready), 32'd0);
      chk($sformatf("stall%0d_mem_we", c), 32'(bus.mem_we), 32'd0);
      @(posedge clk); #1;
    end
    bus.d_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.d_rsp_ready = 1'b0;
    chk("stall_release_valid", 32'(bus.d_rsp_valid), 32'd0);
    chk("stall_release_i_ready", 32'(bus.i_req_ready), 32'd1);
    bus.i_req_valid = 1'b0;

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      strb = 4'($urandom);
      wd   = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = 32'd65533 + 32'($urandom_range(0, 2));
        1:       addr = 32'h0001_0000 | $urandom;
        default: addr = 32'h0400 + 32'($urandom_range(0, 63));
      endcase
      model(addr, we, strb, wd, exp_rd, exp_er, exp_lat, exp_wc);
      do_txn(is_d, addr, we, strb, wd, rd, er, lat, wc, acc);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(exp_er));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_we_cycles", i), 32'(wc), 32'(exp_wc));
    end
    for (int a = 16'h0400; a < 16'h0440; a += 4) begin
      for (int k = 0; k < 4; k++) exp_rd[k] = ref_mem[idx(16'(a), k)];
      chk($sformatf("rnd_mem_%0h", a), peek_word(16'(a)), exp_rd);
    end

    // Reset landing in MERGE_WR
    @(negedge clk);
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h300; bus.d_req_we = 1'b1;
    bus.d_req_strb = 4'b0100; bus.d_req_wdata = 32'h0000_7700;
    #1;
    chk("rstmid_d_ready", 32'(bus.d_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.d_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_merge_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_we_drop", 32'(bus.mem_we), 32'd0);
    chk("rstmid_addr_zero", bus.mem_addr, 32'd0);
    chk("rstmid_no_rsp", 32'(bus.d_rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.d_rsp_valid || bus.i_rsp_valid || bus.mem_we) n++;
    end
    chk("rstmid_quiet_after", 32'(n), 32'd0);
    wd = peek_word(16'h0300);
    chk("rstmid_word_whole", 32'(wd == 32'h0506_0708 || wd == 32'h0506_7708), 32'd1);
    do_txn(1'b1, 32'h300, 1'b0, 4'h0, '0, rd, er, lat, wc, acc);
    chk("rstmid_reload_rdata", rd, wd);
    chk("rstmid_reload_latency", 32'(lat), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
